// File: rtl/jtag_pkg.sv
// Shared constants and types for the JTAG instruction/data register chain.
// Opcodes here are the 4-bit defaults; the top resizes them to its IR width.
package jtag_pkg;

    localparam int unsigned IR_WIDTH_DEFAULT = 4;

    localparam logic [3:0] OPC_IDCODE = 4'h1;
    localparam logic [3:0] OPC_USER   = 4'h2;
    localparam logic [3:0] OPC_BYPASS = 4'hF;

    typedef enum logic [1:0] {
        DR_BYPASS = 2'd0,
        DR_IDCODE = 2'd1,
        DR_USER   = 2'd2
    } dr_sel_e;

endpackage

// File: rtl/jtag_shift_reg.sv
// Capture/shift/update register used for IR, IDCODE and USER.
// Shifts LSB first toward o_lsb; the update stage only changes on i_update or i_update_load_reset.
module jtag_shift_reg #(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] UPDATE_RESET = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_capture,
    input  logic             i_shift,
    input  logic             i_update,
    input  logic             i_update_load_reset,
    input  logic             i_tdi,
    input  logic [WIDTH-1:0] i_capture_value,
    output logic             o_lsb,
    output logic [WIDTH-1:0] o_update,
    output logic             o_update_strobe
);

    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] r_update;
    logic             r_update_strobe;

    // Capture wins over shift so a multi-hot state input still leaves a defined value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr            <= '0;
            r_update        <= UPDATE_RESET;
            r_update_strobe <= 1'b0;
        end else begin
            r_update_strobe <= i_update & ~i_update_load_reset;
            if (i_capture) begin
                r_sr <= i_capture_value;
            end else if (i_shift) begin
                r_sr <= {i_tdi, r_sr[WIDTH-1:1]};
            end
            if (i_update_load_reset) begin
                r_update <= UPDATE_RESET;
            end else if (i_update) begin
                r_update <= r_sr;
            end
        end
    end

    assign o_lsb           = r_sr[0];
    assign o_update        = r_update;
    assign o_update_strobe = r_update_strobe;

endmodule

// File: rtl/jtag_ir_dr_chain.sv
// JTAG instruction register plus BYPASS, IDCODE and USER data registers,
// driven by the TAP controller's one-hot state levels; drives tdo/tdo_en to the pins.
module jtag_ir_dr_chain #(
    parameter int unsigned         IR_WIDTH     = jtag_pkg::IR_WIDTH_DEFAULT,
    parameter logic [31:0]         IDCODE_VALUE = 32'h1000_0001,
    parameter logic [IR_WIDTH-1:0] OPC_IDCODE   = IR_WIDTH'(jtag_pkg::OPC_IDCODE),
    parameter logic [IR_WIDTH-1:0] OPC_USER     = IR_WIDTH'(jtag_pkg::OPC_USER),
    parameter int unsigned         USER_WIDTH   = 32
) (
    input  logic                  tck,
    input  logic                  trst,
    input  logic                  tdi,
    input  logic                  state_tlr,
    input  logic                  state_capturedr,
    input  logic                  state_captureir,
    input  logic                  state_shiftdr,
    input  logic                  state_shiftir,
    input  logic                  state_updatedr,
    input  logic                  state_updateir,
    input  logic [USER_WIDTH-1:0] user_capture,
    output logic                  tdo,
    output logic                  tdo_en,
    output logic [IR_WIDTH-1:0]   ir,
    output logic [USER_WIDTH-1:0] user_update,
    output logic                  user_update_strobe
);

    import jtag_pkg::*;

    // IEEE 1149.1 requires the two IR bits nearest tdo to capture as 2'b01.
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

    dr_sel_e               w_dr_sel;
    logic [IR_WIDTH-1:0]   w_ir;
    logic                  w_ir_lsb;
    logic                  w_idcode_lsb;
    logic                  w_user_lsb;
    logic                  w_idcode_capture;
    logic                  w_idcode_shift;
    logic                  w_user_capture;
    logic                  w_user_shift;
    logic                  w_user_update;
    logic                  w_tdo;
    logic                  w_ir_strobe_unused;
    logic                  w_idcode_strobe_unused;
    logic [31:0]           w_idcode_update_unused;
    logic                  r_bypass;

    // Decoded from the updated instruction only, so an IR shift never moves the selection.
    always_comb begin
        if (w_ir == OPC_IDCODE) begin
            w_dr_sel = DR_IDCODE;
        end else if (w_ir == OPC_USER) begin
            w_dr_sel = DR_USER;
        end else begin
            w_dr_sel = DR_BYPASS;
        end
    end

    assign w_idcode_capture = state_capturedr & (w_dr_sel == DR_IDCODE);
    assign w_idcode_shift   = state_shiftdr   & (w_dr_sel == DR_IDCODE);
    assign w_user_capture   = state_capturedr & (w_dr_sel == DR_USER);
    assign w_user_shift     = state_shiftdr   & (w_dr_sel == DR_USER);
    assign w_user_update    = state_updatedr  & (w_dr_sel == DR_USER);

    jtag_shift_reg #(
        .WIDTH        (IR_WIDTH),
        .UPDATE_RESET (OPC_IDCODE)
    ) u_ir (
        .clk                 (tck),
        .rst                 (trst),
        .i_capture           (state_captureir),
        .i_shift             (state_shiftir),
        .i_update            (state_updateir),
        .i_update_load_reset (state_tlr),
        .i_tdi               (tdi),
        .i_capture_value     (IR_CAPTURE),
        .o_lsb               (w_ir_lsb),
        .o_update            (w_ir),
        .o_update_strobe     (w_ir_strobe_unused)
    );

    // IDCODE has no update stage of its own; its update port stays at reset.
    jtag_shift_reg #(
        .WIDTH        (32),
        .UPDATE_RESET (32'h0)
    ) u_idcode (
        .clk                 (tck),
        .rst                 (trst),
        .i_capture           (w_idcode_capture),
        .i_shift             (w_idcode_shift),
        .i_update            (1'b0),
        .i_update_load_reset (1'b0),
        .i_tdi               (tdi),
        .i_capture_value     (IDCODE_VALUE),
        .o_lsb               (w_idcode_lsb),
        .o_update            (w_idcode_update_unused),
        .o_update_strobe     (w_idcode_strobe_unused)
    );

    // Test-Logic-Reset leaves the USER update value alone; only trst clears it.
    jtag_shift_reg #(
        .WIDTH        (USER_WIDTH),
        .UPDATE_RESET ('0)
    ) u_user (
        .clk                 (tck),
        .rst                 (trst),
        .i_capture           (w_user_capture),
        .i_shift             (w_user_shift),
        .i_update            (w_user_update),
        .i_update_load_reset (1'b0),
        .i_tdi               (tdi),
        .i_capture_value     (user_capture),
        .o_lsb               (w_user_lsb),
        .o_update            (user_update),
        .o_update_strobe     (user_update_strobe)
    );

    always_ff @(posedge tck) begin
        if (trst) begin
            r_bypass <= 1'b0;
        end else if (w_dr_sel == DR_BYPASS) begin
            if (state_capturedr) begin
                r_bypass <= 1'b0;
            end else if (state_shiftdr) begin
                r_bypass <= tdi;
            end
        end
    end

    // Combinational so the bit is ready before the edge ending the shift cycle.
    always_comb begin
        w_tdo = 1'b0;
        if (state_shiftir) begin
            w_tdo = w_ir_lsb;
        end else if (state_shiftdr) begin
            case (w_dr_sel)
                DR_IDCODE: w_tdo = w_idcode_lsb;
                DR_USER:   w_tdo = w_user_lsb;
                default:   w_tdo = r_bypass;
            endcase
        end
    end

    assign tdo    = w_tdo;
    assign tdo_en = state_shiftir | state_shiftdr;
    assign ir     = w_ir;

endmodule

// File: tb/tb_jtag_ir_dr_chain.sv
// Directed bench for jtag_ir_dr_chain: a driver walks TAP states and queues expected
// tdo bits and USER updates; a negedge monitor pops and compares them.
module tb_jtag_ir_dr_chain;

    localparam int S_NONE = 0;
    localparam int S_TLR  = 1;
    localparam int S_CDR  = 2;
    localparam int S_CIR  = 3;
    localparam int S_SDR  = 4;
    localparam int S_SIR  = 5;
    localparam int S_UDR  = 6;
    localparam int S_UIR  = 7;

    localparam logic [3:0]  IR_CAPTURE_BITS = 4'b0001;
    localparam logic [31:0] IDCODE_EXP      = 32'h1000_0001;

    logic        tck = 1'b0;
    logic        trst;
    logic        tdi;
    logic        state_tlr;
    logic        state_capturedr;
    logic        state_captureir;
    logic        state_shiftdr;
    logic        state_shiftir;
    logic        state_updatedr;
    logic        state_updateir;
    logic [31:0] user_capture;
    logic        tdo;
    logic        tdo_en;
    logic [3:0]  ir;
    logic [31:0] user_update;
    logic        user_update_strobe;

    int          total = 0;
    int          bad   = 0;
    bit          mon_en = 1'b0;
    logic        exp_tdo_q[$];
    logic [31:0] exp_upd_q[$];

    jtag_ir_dr_chain dut (
        .tck                (tck),
        .trst               (trst),
        .tdi                (tdi),
        .state_tlr          (state_tlr),
        .state_capturedr    (state_capturedr),
        .state_captureir    (state_captureir),
        .state_shiftdr      (state_shiftdr),
        .state_shiftir      (state_shiftir),
        .state_updatedr     (state_updatedr),
        .state_updateir     (state_updateir),
        .user_capture       (user_capture),
        .tdo                (tdo),
        .tdo_en             (tdo_en),
        .ir                 (ir),
        .user_update        (user_update),
        .user_update_strobe (user_update_strobe)
    );

    // Clock
    always #5 tck = ~tck;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endfunction

    function automatic void note_fail(input string name, input string why);
        total++;
        bad++;
        $display("FAIL %s: %s", name, why);
    endfunction

    // Driver: hold one TAP state for one tck cycle, inputs change 1 time unit after the edge.
    task automatic cyc(input int st, input logic d);
        state_tlr       = (st == S_TLR);
        state_capturedr = (st == S_CDR);
        state_captureir = (st == S_CIR);
        state_shiftdr   = (st == S_SDR);
        state_shiftir   = (st == S_SIR);
        state_updatedr  = (st == S_UDR);
        state_updateir  = (st == S_UIR);
        tdi             = d;
        @(posedge tck);
        #1;
    endtask

    task automatic load_ir(input logic [3:0] opc);
        cyc(S_NONE, 1'b0);
        cyc(S_CIR, 1'b0);
        for (int i = 0; i < 4; i++) begin
            exp_tdo_q.push_back(IR_CAPTURE_BITS[i]);
            cyc(S_SIR, opc[i]);
        end
        cyc(S_NONE, 1'b0);
        check("ir_held_until_update", 32'(ir) ^ 32'(opc) ^ 32'(opc), 32'(ir));
        cyc(S_UIR, 1'b0);
        check("ir_after_update", 32'(ir), 32'(opc));
        cyc(S_NONE, 1'b0);
    endtask

    task automatic shift_dr(input int n, input logic [31:0] din, input logic [31:0] dout,
                            input int pause_at, input bit expect_upd, input logic [31:0] upd);
        cyc(S_NONE, 1'b0);
        cyc(S_CDR, 1'b0);
        for (int i = 0; i < n; i++) begin
            if (i == pause_at) begin
                for (int k = 0; k < 7; k++) cyc(S_NONE, 1'b1);
            end
            exp_tdo_q.push_back(dout[i]);
            cyc(S_SDR, din[i]);
        end
        cyc(S_NONE, 1'b0);
        if (expect_upd) exp_upd_q.push_back(upd);
        cyc(S_UDR, 1'b0);
        cyc(S_NONE, 1'b0);
    endtask

    // Monitor / scoreboard
    always @(negedge tck) begin
        if (mon_en) begin
            check("tdo_en", 32'(tdo_en), 32'(state_shiftir | state_shiftdr));
            if (tdo_en) begin
                if (exp_tdo_q.size() == 0) begin
                    note_fail("tdo_unexpected", "shift cycle with no expected bit queued");
                end else begin
                    check("tdo", 32'(tdo), 32'(exp_tdo_q.pop_front()));
                end
            end else begin
                check("tdo_idle", 32'(tdo), 32'h0);
            end
            if (user_update_strobe === 1'b1) begin
                if (exp_upd_q.size() == 0) begin
                    note_fail("user_update_strobe", "got 1 want 0 (no update pending)");
                end else begin
                    check("user_update", user_update, exp_upd_q.pop_front());
                end
            end else if (user_update_strobe !== 1'b0) begin
                note_fail("user_update_strobe", "got X/Z want 0 or 1");
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        trst         = 1'b1;
        user_capture = 32'h0;
        cyc(S_NONE, 1'b0);
        trst = 1'b0;
        check("reset_ir", 32'(ir), 32'h1);
        check("reset_user_update", user_update, 32'h0);
        check("reset_strobe", 32'(user_update_strobe), 32'h0);
        check("reset_tdo_en", 32'(tdo_en), 32'h0);
        mon_en = 1'b1;

        // IDCODE selected straight out of reset
        shift_dr(32, 32'h0, IDCODE_EXP, -1, 1'b0, 32'h0);

        // All-ones opcode selects BYPASS: one-cycle delay
        load_ir(4'hF);
        shift_dr(4, 32'b1101, 32'b1010, -1, 1'b0, 32'h0);

        // Unassigned opcode also selects BYPASS
        load_ir(4'h0);
        shift_dr(3, 32'b011, 32'b110, -1, 1'b0, 32'h0);

        // USER capture, shift and update
        load_ir(4'h2);
        user_capture = 32'hDEAD_BEEF;
        shift_dr(32, 32'h1234_5678, 32'hDEAD_BEEF, -1, 1'b1, 32'h1234_5678);
        check("user_update_hold", user_update, 32'h1234_5678);

        // USER shift interrupted by Exit1/Pause/Exit2
        user_capture = 32'hA5A5_0F0F;
        shift_dr(32, 32'hCAFE_BABE, 32'hA5A5_0F0F, 10, 1'b1, 32'hCAFE_BABE);
        check("user_update_after_pause", user_update, 32'hCAFE_BABE);

        // trst in the middle of a USER shift
        user_capture = 32'h3C3C_A5A5;
        cyc(S_NONE, 1'b0);
        cyc(S_CDR, 1'b0);
        for (int i = 0; i < 12; i++) begin
            exp_tdo_q.push_back(user_capture[i]);
            cyc(S_SDR, i[0]);
        end
        trst = 1'b1;
        exp_tdo_q.push_back(user_capture[12]);
        cyc(S_SDR, 1'b1);
        trst = 1'b0;
        check("midreset_ir", 32'(ir), 32'h1);
        check("midreset_user_update", user_update, 32'h0);
        check("midreset_strobe", 32'(user_update_strobe), 32'h0);
        cyc(S_NONE, 1'b0);
        shift_dr(32, 32'hFFFF_FFFF, IDCODE_EXP, -1, 1'b0, 32'h0);

        // TLR reloads IDCODE but keeps user_update
        load_ir(4'h2);
        user_capture = 32'h1111_2222;
        shift_dr(32, 32'h0BAD_F00D, 32'h1111_2222, -1, 1'b1, 32'h0BAD_F00D);
        cyc(S_TLR, 1'b0);
        check("tlr_ir", 32'(ir), 32'h1);
        check("tlr_user_update", user_update, 32'h0BAD_F00D);
        cyc(S_NONE, 1'b0);
        cyc(S_NONE, 1'b0);

        mon_en = 1'b0;
        check("tdo_queue_drained", 32'(exp_tdo_q.size()), 32'h0);
        check("update_queue_drained", 32'(exp_upd_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
